// File: rtl/vga_timing_if.sv
// Pixel-side bundle between the VGA timing controller and its
// pixel generator / DAC pins.
interface vga_timing_if;
   logic [15:0] rgb_data;
   logic [11:0] addr_h;
   logic [11:0] addr_v;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [15:0] rgb_out;
   logic        frame_start;

   modport master (
      input  rgb_data,
      output addr_h, addr_v, hsync, vsync, de, rgb_out, frame_start
   );

   modport slave (
      output rgb_data,
      input  addr_h, addr_v, hsync, vsync, de, rgb_out, frame_start
   );
endinterface

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 raster timing with prefetch-aligned pixel requests
// and registered, pipeline-aligned VGA outputs.
module vga_timing_ctrl #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int PREFETCH = 1,
   parameter bit SYNC_POL = 1'b0
) (
   input logic          vga_clk,
   input logic          rst,
   vga_timing_if.master vga
);
   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HS      = H_SYNC + H_BACK;

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_SW   = 12'(H_SYNC);
   localparam logic [11:0] V_SW   = 12'(V_SYNC);
   localparam logic [11:0] RQ_H0  = 12'(HS - PREFETCH);
   localparam logic [11:0] RQ_H1  = 12'(HS - PREFETCH + H_ACTIVE - 1);
   localparam logic [11:0] RQ_V0  = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] RQ_V1  = 12'(V_SYNC + V_BACK + V_ACTIVE - 1);

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic fs;
   } side_t;

   localparam side_t SIDE_RST = '{
      hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, fs: 1'b0
   };

   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;
   logic        req_valid;
   logic        req_dly;
   side_t       side_raw;
   side_t       dl_q [PREFETCH+1];
   logic [15:0] rgb_q;

   // Raster position: h wraps every line, v advances on h wrap.
   always_comb begin
      h_cnt_d = h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // The request window leads the visible area by PREFETCH clocks,
   // so it doubles as the raw display-enable once delayed.
   always_comb begin
      req_valid = (v_cnt_q >= RQ_V0) && (v_cnt_q <= RQ_V1) &&
                  (h_cnt_q >= RQ_H0) && (h_cnt_q <= RQ_H1);
      side_raw.hs = (h_cnt_q < H_SW) ? SYNC_POL : ~SYNC_POL;
      side_raw.vs = (v_cnt_q < V_SW) ? SYNC_POL : ~SYNC_POL;
      side_raw.de = req_valid;
      side_raw.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   assign vga.addr_h = req_valid ? (h_cnt_q - RQ_H0 + 12'd1) : '0;
   assign vga.addr_v = req_valid ? (v_cnt_q - RQ_V0 + 12'd1) : '0;

   // Sideband delay line, PREFETCH+1 deep, lines up with rgb_out.
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= PREFETCH; k++) dl_q[k] <= SIDE_RST;
      end else begin
         dl_q[0] <= side_raw;
         for (int k = 1; k <= PREFETCH; k++) dl_q[k] <= dl_q[k-1];
      end
   end

   generate
      if (PREFETCH == 0) begin : g_req_now
         assign req_dly = req_valid;
      end else begin : g_req_pipe
         logic [PREFETCH-1:0] req_q;
         // Request qualifier delayed to the rgb_data capture cycle.
         always_ff @(posedge vga_clk or posedge rst) begin
            if (rst) begin
               req_q <= '0;
            end else begin
               req_q[0] <= req_valid;
               for (int k = 1; k < PREFETCH; k++) req_q[k] <= req_q[k-1];
            end
         end
         assign req_dly = req_q[PREFETCH-1];
      end
   endgenerate

   // Capture generator pixel only for in-window requests.
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) rgb_q <= '0;
      else     rgb_q <= req_dly ? vga.rgb_data : 16'd0;
   end

   assign vga.hsync       = dl_q[PREFETCH].hs;
   assign vga.vsync       = dl_q[PREFETCH].vs;
   assign vga.de          = dl_q[PREFETCH].de;
   assign vga.frame_start = dl_q[PREFETCH].fs;
   assign vga.rgb_out     = rgb_q;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Random-reset, random-pixel bench for vga_timing_ctrl with an
// arithmetic raster model; one small-geometry and one default DUT.
module tb_vga_timing_ctrl;
   typedef struct packed {
      int hsy; int hbk; int hact; int hfr;
      int vsy; int vbk; int vact; int vfr;
      int pf;
   } geo_t;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic        fs;
      logic [15:0] rgb;
      logic [11:0] ah;
      logic [11:0] av;
   } exp_t;

   localparam geo_t GS = '{hsy: 3, hbk: 4, hact: 8, hfr: 2,
                           vsy: 2, vbk: 2, vact: 4, vfr: 1, pf: 2};
   localparam geo_t GD = '{hsy: 96, hbk: 48, hact: 640, hfr: 16,
                           vsy: 2, vbk: 33, vact: 480, vfr: 10, pf: 1};
   localparam int D_END = 28900;

   logic        vga_clk = 1'b0;
   logic        rst_s   = 1'b0;
   logic        rst_d   = 1'b0;
   logic        run     = 1'b0;
   int          checks  = 0;
   int          errors  = 0;
   int          n_s     = 0;
   int          n_d     = 0;
   int          de_cnt_d = 0;
   logic [15:0] key_s, key_d;
   logic [23:0] hist_s [$];
   logic [23:0] hist_d [$];

   vga_timing_if if_s ();
   vga_timing_if if_d ();

   vga_timing_ctrl #(
      .H_SYNC(3), .H_BACK(4), .H_ACTIVE(8), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
      .PREFETCH(2), .SYNC_POL(1'b0)
   ) dut_s (
      .vga_clk(vga_clk),
      .rst    (rst_s),
      .vga    (if_s)
   );

   vga_timing_ctrl dut_d (
      .vga_clk(vga_clk),
      .rst    (rst_d),
      .vga    (if_d)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [15:0] pix(int col, int row, logic [15:0] key);
      return 16'(col * 37 + row * 1031) ^ key;
   endfunction

   // Outputs expected n clocks after reset release, from raster rules.
   function automatic exp_t model(geo_t g, int n, logic [15:0] key);
      exp_t e;
      int ht, vt, h, v, col, row, q, lead;
      ht   = g.hsy + g.hbk + g.hact + g.hfr;
      vt   = g.vsy + g.vbk + g.vact + g.vfr;
      lead = g.hsy + g.hbk - g.pf;
      h = n % ht;
      v = (n / ht) % vt;
      col = h - lead;
      row = v - (g.vsy + g.vbk);
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      if (col >= 0 && col < g.hact && row >= 0 && row < g.vact) begin
         e.ah = 12'(col + 1);
         e.av = 12'(row + 1);
      end
      if (n >= g.pf + 1) begin
         q = n - g.pf - 1;
         h = q % ht;
         v = (q / ht) % vt;
         e.hs = !(h < g.hsy);
         e.vs = !(v < g.vsy);
         e.fs = (h == 0) && (v == 0);
         col = h - lead;
         row = v - (g.vsy + g.vbk);
         if (col >= 0 && col < g.hact && row >= 0 && row < g.vact) begin
            e.de  = 1'b1;
            e.rgb = pix(col + 1, row + 1, key);
         end
      end
      return e;
   endfunction

   task automatic check_cycle(input string p, input geo_t g, input int n,
                              input logic in_rst, input logic [15:0] key,
                              input exp_t o);
      exp_t e;
      if (in_rst) begin
         e = '0;
         e.hs = 1'b1;
         e.vs = 1'b1;
      end else begin
         e = model(g, n, key);
      end
      chk({p, "_hsync"}, 32'(o.hs), 32'(e.hs));
      chk({p, "_vsync"}, 32'(o.vs), 32'(e.vs));
      chk({p, "_de"},    32'(o.de), 32'(e.de));
      chk({p, "_fs"},    32'(o.fs), 32'(e.fs));
      chk({p, "_rgb"},   32'(o.rgb), 32'(e.rgb));
      chk({p, "_addr_h"}, 32'(o.ah), 32'(e.ah));
      chk({p, "_addr_v"}, 32'(o.av), 32'(e.av));
   endtask

   function automatic logic [15:0] gen(logic [23:0] a, logic [15:0] key);
      if (a[23:12] != '0) return pix(int'(a[23:12]), int'(a[11:0]), key);
      return ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom);
   endfunction

   always @(posedge vga_clk or posedge rst_s)
      if (rst_s) n_s <= 0;
      else       n_s <= n_s + 1;

   always @(posedge vga_clk or posedge rst_d)
      if (rst_d) n_d <= 0;
      else       n_d <= n_d + 1;

   always @(negedge vga_clk) begin : s_side
      logic [23:0] a;
      if (run) begin
         check_cycle("s", GS, n_s, rst_s, key_s,
                     '{if_s.hsync, if_s.vsync, if_s.de, if_s.frame_start,
                       if_s.rgb_out, if_s.addr_h, if_s.addr_v});
         hist_s.push_back({if_s.addr_h, if_s.addr_v});
         a = (hist_s.size() > GS.pf) ? hist_s.pop_front() : 24'd0;
         if_s.rgb_data = gen(a, key_s);
      end
   end

   always @(negedge vga_clk) begin : d_side
      logic [23:0] a;
      if (run) begin
         check_cycle("d", GD, n_d, rst_d, key_d,
                     '{if_d.hsync, if_d.vsync, if_d.de, if_d.frame_start,
                       if_d.rgb_out, if_d.addr_h, if_d.addr_v});
         if (!rst_d && if_d.de) de_cnt_d++;
         if (!rst_d && n_d == D_END) chk("d_de_line35", de_cnt_d, 640);
         hist_d.push_back({if_d.addr_h, if_d.addr_v});
         a = (hist_d.size() > GD.pf) ? hist_d.pop_front() : 24'd0;
         if_d.rgb_data = gen(a, key_d);
      end
   end

   initial begin
      key_s = 16'($urandom);
      key_d = 16'($urandom);
      if_s.rgb_data = '0;
      if_d.rgb_data = '0;
      #1;
      rst_s = 1'b1;
      rst_d = 1'b1;
      run   = 1'b1;
      repeat (10) @(posedge vga_clk);
      #2;
      rst_s = 1'b0;
      rst_d = 1'b0;
      while (n_d <= D_END + 2) begin
         repeat ($urandom_range(40, 500)) @(posedge vga_clk);
         #2 rst_s = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge vga_clk);
         #2 rst_s = 1'b0;
      end
      repeat (3) @(posedge vga_clk);
      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
